exec_unit: RTL and testbench
============================

# exec_unit

Registered execute stage placed directly downstream of the 16-entry register file. It consumes the two register-file read operands (or an immediate), performs one ALU, shift or multi-cycle multiply operation, and holds the processor status flags. It returns a one-cycle write-back strobe, a destination address and the result to the register file's write port.

## Interface
- WIDTH, 16, datapath width
- REGBITS, 4, register address width
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  4  operation code (see Operation)
- opa  in  WIDTH  destination-register operand (regfile readData1)
- opb  in  WIDTH  source-register operand (regfile readData2)
- imm  in  8  immediate, sign-extended to WIDTH
- use_imm  in  1  1: operand B = sext(imm); 0: operand B = opb
- dest_in  in  REGBITS  destination register address
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse: result valid
- wr_en  out  1  regWrite strobe, coincident with done
- dest_out  out  REGBITS  registered dest_in, valid with done
- result  out  WIDTH  registered result, held until next done
- flags  out  5  {C, L, F, Z, N} PSR bits

## Operation
- Operand capture occurs at the edge where start=1 in IDLE: op, A=opa, B (per use_imm), dest_in. Later input changes are ignored until the next IDLE.
- Opcodes:
  - 0 NOP
  - 1 ADD: A+B
  - 2 SUB: A−B
  - 3 CMP: A vs B, no write-back
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 MOV: result=B
  - 8 LSH: shift A by signed B[4:0]. Positive shifts left, negative shifts logical right. Magnitude ≥16 yields 0.
  - 9 MUL: low WIDTH bits of unsigned A×B
  - 10–15: treated as NOP
- Flag updates:
  - ADD: C = carry-out; F = signed overflow
  - SUB: C = borrow (A<B unsigned); F = signed overflow
  - CMP: Z = (A==B); L = A<B unsigned; N = A<B signed
  - All other ops leave flags unchanged. Unaffected flag bits hold their values.
- wr_en=1 with done for ADD, SUB, AND, OR, XOR, MOV, LSH, MUL. wr_en=0 for CMP, NOP and undefined opcodes; done still pulses for these.
- All arithmetic is modulo 2^WIDTH; the carry comes from a WIDTH+1-bit sum.
- FSM states:
  - IDLE: start → EXEC (non-MUL) or MULT (MUL)
  - EXEC → DONE. The result is registered on this edge.
  - MULT: 16 shift-add iterations, counter 0..15. At count 15 → DONE with the product registered.
  - DONE: done=1, wr_en as above → IDLE
- Reset values: state IDLE; busy, done, wr_en = 0; result, dest_out, flags = 0; counter = 0.
- start while busy: ignored, with no queuing and no side effects.
- Reset asserted mid-MULT or in DONE aborts immediately. The done/wr_en pulse is suppressed, and the partial product and flags are cleared.

## Timing
- Start sampled at edge k. Non-MUL: done/wr_en high in the cycle after edge k+1. MUL: done/wr_en high in the cycle after edge k+17.
- busy rises after edge k and falls after the edge ending DONE. The next start is accepted at the first edge with busy=0.
- Maximum issue rate: non-MUL, one operation per 3 cycles; MUL, one per 19 cycles.
- result, dest_out and flags change only on the DONE-entry edge. They are stable for the whole done cycle and held afterwards.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package exec_pkg holds:
  - opcode constants OP_NOP..OP_MUL
  - FSM state encoding
  - flag bit indices FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0
- Sub-module seq_multiplier is the natural split: a shift-add multiplier with load/step/count, instantiated once. The remaining ALU/shift logic is combinational inside exec_unit.

## Test plan
- Reset mid-MULT (A=0x00FF, B=0x0101, reset pulled low at cycle 8) → outputs 0 immediately, no done pulse. A subsequent ADD 1+1 → result 0x0002.
- ADD A=0xFFFF, B=0x0001 → result 0x0000, C=1, F=0, wr_en=1, dest_out=dest_in, done 2 cycles after the start edge.
- SUB A=0x8000, B=0x0001 → 0x7FFF, F=1, C=0. CMP A=0xFFFF, B=0x0001 → wr_en=0, Z=0, L=0, N=1, while C and F retain their SUB values.
- LSH A=0x0F0F, use_imm=1, imm=0xFC (−4) → 0x00F0. imm=0x04 → 0xF0F0. imm=0x10 → 0x0000.
- MUL A=0x0123, B=0x0010 → 0x1230 with done 18 cycles after the start edge. A start pulsed at cycle 5 of the MUL is ignored, and busy stays high throughout.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state encoding and PSR flag indices shared by the execute stage.
// Rev 1.0
`default_nettype none

package exec_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_CMP = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_LSH = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic writes_back(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_MUL: writes_back = 1'b1;
      default:                                                      writes_back = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per step, low WIDTH bits kept.
// Rev 1.0
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             active,
  output logic             last,
  output logic [WIDTH-1:0] product_next
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  // Accumulator value after the current step; on the last step this is the product.
  assign product_next = acc + (mplier[0] ? mcand : '0);
  assign last         = active && (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      count  <= '0;
      active <= 1'b1;
    end else if (step && active) begin
      acc    <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (last) active <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// exec_unit: registered execute stage (ALU, shifter, sequential multiply) with PSR flags.
// Rev 1.0
`default_nettype none

module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [7:0]         imm,
  input  logic               use_imm,
  input  logic [REGBITS-1:0] dest_in,
  output logic               busy,
  output logic               done,
  output logic               wr_en,
  output logic [REGBITS-1:0] dest_out,
  output logic [WIDTH-1:0]   result,
  output logic [4:0]         flags
);

  state_t state, state_next;

  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [REGBITS-1:0] dest_q;

  logic [WIDTH-1:0] imm_ext;
  logic             mul_load;
  logic             mul_step;
  logic             mul_active;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [4:0]       sh;
  logic [4:0]       sh_mag;

  assign imm_ext = {{(WIDTH-8){imm[7]}}, imm};
  assign busy    = (state != S_IDLE);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .load         (mul_load),
    .step         (mul_step),
    .mcand_in     (a_q),
    .mplier_in    (b_q),
    .active       (mul_active),
    .last         (mul_last),
    .product_next (mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // The first MULT cycle loads the multiplier, then 16 steps follow.
  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = (op == OP_MUL) ? S_MULT : S_EXEC;
      S_EXEC: state_next = S_DONE;
      S_MULT: begin
        if (!mul_active) begin
          mul_load = 1'b1;
        end else begin
          mul_step = 1'b1;
          if (mul_last) state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res   = result;
    alu_flags = flags;
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    sh        = b_q[4:0];
    sh_mag    = -sh;
    case (op_q)
      OP_ADD: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res           = diff[WIDTH-1:0];
        alu_flags[FLAG_C] = diff[WIDTH];
        alu_flags[FLAG_F] = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_CMP: begin
        alu_flags[FLAG_Z] = (a_q == b_q);
        alu_flags[FLAG_L] = (a_q < b_q);
        alu_flags[FLAG_N] = ($signed(a_q) < $signed(b_q));
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = b_q;
      OP_LSH: begin
        // A negative amount of -16 is the only magnitude that reaches 16.
        if (!sh[4])         alu_res = a_q << sh[3:0];
        else if (sh_mag[4]) alu_res = '0;
        else                alu_res = a_q >> sh_mag[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_NOP;
      a_q      <= '0;
      b_q      <= '0;
      dest_q   <= '0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      dest_out <= '0;
      result   <= '0;
      flags    <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        op_q   <= op;
        a_q    <= opa;
        b_q    <= use_imm ? imm_ext : opb;
        dest_q <= dest_in;
      end
      if (state == S_EXEC) begin
        result   <= alu_res;
        flags    <= alu_flags;
        dest_out <= dest_q;
        done     <= 1'b1;
        wr_en    <= writes_back(op_q);
      end
      if (mul_step && mul_last) begin
        result   <= mul_product;
        dest_out <= dest_q;
        done     <= 1'b1;
        wr_en    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vector table, multi-cycle corner sequences and random ops vs a reference model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_exec_unit;
  import exec_pkg::*;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         op = 4'd0;
  logic [WIDTH-1:0]   opa = '0;
  logic [WIDTH-1:0]   opb = '0;
  logic [7:0]         imm = 8'd0;
  logic               use_imm = 1'b0;
  logic [REGBITS-1:0] dest_in = '0;
  logic               busy, done, wr_en;
  logic [REGBITS-1:0] dest_out;
  logic [WIDTH-1:0]   result;
  logic [4:0]         flags;

  exec_unit #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .imm      (imm),
    .use_imm  (use_imm),
    .dest_in  (dest_in),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .dest_out (dest_out),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: architectural result register and PSR.
  logic [15:0] m_result = '0;
  logic [4:0]  m_flags  = '0;

  task automatic model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, output logic wr);
    longint ua, ub, sa, sb, r;
    int k;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    case (o)
      4'd1: begin
        r = ua + ub;
        m_result = 16'(r);
        m_flags[FLAG_C] = (r > 65535);
        m_flags[FLAG_F] = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd2: begin
        r = ua - ub;
        m_result = 16'(r);
        m_flags[FLAG_C] = (ua < ub);
        m_flags[FLAG_F] = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd3: begin
        wr = 1'b0;
        m_flags[FLAG_Z] = (ua == ub);
        m_flags[FLAG_L] = (ua < ub);
        m_flags[FLAG_N] = (sa < sb);
      end
      4'd4: m_result = a & b;
      4'd5: m_result = a | b;
      4'd6: m_result = a ^ b;
      4'd7: m_result = b;
      4'd8: begin
        k = int'(b & 16'h001f);
        if (k >= 16) k = k - 32;
        if (k >= 0)        m_result = 16'(ua * (longint'(1) << k));
        else if (-k >= 16) m_result = 16'h0000;
        else               m_result = 16'(ua / (longint'(1) << (-k)));
      end
      4'd9: m_result = 16'(ua * ub);
      default: wr = 1'b0;
    endcase
  endtask

  // Issue one op from a negedge with busy low; returns the done latency in edges (-1 on timeout).
  task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] im, input logic ui, input logic [3:0] d,
                       input int poke, output int lat, output logic busy_ok);
    op = o; opa = a; opb = b; imm = im; use_imm = ui; dest_in = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'(OP_ADD); opa = 16'($urandom); opb = 16'($urandom);
    imm = 8'($urandom); use_imm = 1'($urandom); dest_in = 4'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      start = (lat == poke);
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    if (!done) lat = -1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic        ui;
    logic [3:0]  dest;
    logic [15:0] res;
    logic [4:0]  flg;
    logic        wr;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lat;
    logic bok, mwr, seen_done;
    logic [15:0] beff;

    tbl[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 1'b0, 4'd3,  16'h0000, 5'h10, 1'b1, 2};
    tbl[1]  = '{OP_SUB, 16'h8000, 16'h0001, 8'h00, 1'b0, 4'd5,  16'h7FFF, 5'h04, 1'b1, 2};
    tbl[2]  = '{OP_CMP, 16'hFFFF, 16'h0001, 8'h00, 1'b0, 4'd6,  16'h7FFF, 5'h05, 1'b0, 2};
    tbl[3]  = '{OP_LSH, 16'h0F0F, 16'h0000, 8'hFC, 1'b1, 4'd7,  16'h00F0, 5'h05, 1'b1, 2};
    tbl[4]  = '{OP_LSH, 16'h0F0F, 16'h0000, 8'h04, 1'b1, 4'd8,  16'hF0F0, 5'h05, 1'b1, 2};
    tbl[5]  = '{OP_LSH, 16'h0F0F, 16'h0000, 8'h10, 1'b1, 4'd9,  16'h0000, 5'h05, 1'b1, 2};
    tbl[6]  = '{OP_MUL, 16'h0123, 16'h0010, 8'h00, 1'b0, 4'd10, 16'h1230, 5'h05, 1'b1, 18};
    tbl[7]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 8'h00, 1'b0, 4'd11, 16'h3030, 5'h05, 1'b1, 2};
    tbl[8]  = '{OP_OR,  16'h0F00, 16'h00F0, 8'h00, 1'b0, 4'd12, 16'h0FF0, 5'h05, 1'b1, 2};
    tbl[9]  = '{OP_XOR, 16'hFFFF, 16'h0F0F, 8'h00, 1'b0, 4'd13, 16'hF0F0, 5'h05, 1'b1, 2};
    tbl[10] = '{OP_MOV, 16'h1111, 16'h2222, 8'h80, 1'b1, 4'd14, 16'hFF80, 5'h05, 1'b1, 2};
    tbl[11] = '{OP_NOP, 16'h1234, 16'h5678, 8'h00, 1'b0, 4'd15, 16'hFF80, 5'h05, 1'b0, 2};
    tbl[12] = '{4'd15,  16'h1234, 16'h5678, 8'h00, 1'b0, 4'd1,  16'hFF80, 5'h05, 1'b0, 2};
    tbl[13] = '{OP_CMP, 16'h1234, 16'h1234, 8'h00, 1'b0, 4'd2,  16'hFF80, 5'h06, 1'b0, 2};
    tbl[14] = '{OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd4,  16'h8000, 5'h06, 1'b1, 2};
    tbl[15] = '{OP_SUB, 16'h0001, 16'h0002, 8'h00, 1'b0, 4'd0,  16'hFFFF, 5'h12, 1'b1, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wr_en", wr_en, 0);
    check("reset result", result, 0);
    check("reset dest_out", dest_out, 0);
    check("reset flags", flags, 0);
    reset = 1'b1;
    @(negedge clk);

    // Nonzero result and carry, then reset mid-MULT clears everything
    do_op(OP_ADD, 16'hFFFF, 16'h0003, 8'h00, 1'b0, 4'd7, -1, lat, bok);
    check("pre add result", result, 16'h0002);
    check("pre add flags", flags, 5'h10);
    @(negedge clk);
    op = OP_MUL; opa = 16'h00FF; opb = 16'h0101; use_imm = 1'b0; dest_in = 4'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("mid mul busy", busy, 1);
    reset = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort wr_en", wr_en, 0);
    check("abort result", result, 0);
    check("abort flags", flags, 0);
    check("abort dest_out", dest_out, 0);
    m_result = '0;
    m_flags  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("no done after abort", seen_done, 0);
    do_op(OP_ADD, 16'h0001, 16'h0001, 8'h00, 1'b0, 4'd1, -1, lat, bok);
    check("add after abort result", result, 16'h0002);
    check("add after abort latency", lat, 2);
    model(OP_ADD, 16'h0001, 16'h0001, mwr);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      beff = tbl[i].ui ? {{8{tbl[i].imm[7]}}, tbl[i].imm} : tbl[i].b;
      model(tbl[i].op, tbl[i].a, beff, mwr);
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].ui, tbl[i].dest, -1, lat, bok);
      check($sformatf("v%0d latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d result", i), result, tbl[i].res);
      check($sformatf("v%0d flags", i), flags, tbl[i].flg);
      check($sformatf("v%0d wr_en", i), wr_en, tbl[i].wr);
      check($sformatf("v%0d dest_out", i), dest_out, tbl[i].dest);
      check($sformatf("v%0d busy", i), bok, 1);
      @(negedge clk);
      check($sformatf("v%0d done drop", i), {done, busy}, 2'b00);
    end

    // Start pulsed at cycle 5 of a MUL is ignored and not queued
    model(OP_MUL, 16'h00FF, 16'h0101, mwr);
    do_op(OP_MUL, 16'h00FF, 16'h0101, 8'h00, 1'b0, 4'd6, 5, lat, bok);
    check("mul poke latency", lat, 18);
    check("mul poke busy", bok, 1);
    check("mul poke result", result, 16'hFFFF);
    check("mul poke dest", dest_out, 4'd6);
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("mul poke no queue", seen_done, 0);

    // Random ops against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [3:0]  ro;
      logic [15:0] ra, rb;
      logic [7:0]  ri;
      logic        ru;
      logic [3:0]  rd;
      ro = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
      ri = 8'($urandom);
      ru = 1'($urandom);
      rd = 4'($urandom);
      beff = ru ? {{8{ri[7]}}, ri} : rb;
      model(ro, ra, beff, mwr);
      do_op(ro, ra, rb, ri, ru, rd, -1, lat, bok);
      check($sformatf("rnd%0d op%0d latency", n, ro), lat, (ro == OP_MUL) ? 18 : 2);
      check($sformatf("rnd%0d op%0d result", n, ro), result, m_result);
      check($sformatf("rnd%0d op%0d flags", n, ro), flags, m_flags);
      check($sformatf("rnd%0d op%0d wr_en", n, ro), wr_en, mwr);
      check($sformatf("rnd%0d op%0d dest", n, ro), dest_out, rd);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
